ysyx_24100012_lsu_ctrl: RTL and testbench
=========================================

Name: ysyx_24100012_lsu_ctrl

Overview:
Multi-cycle load/store controller between the EXU and the data-memory bus. Accepts one load or store per handshake and issues a word-aligned bus transaction with byte strobes. Extracts and sign/zero-extends sub-word load data from the correct byte lane, then returns a response. Handles the full RV32 load/store width set (LB/LH/LW/LBU/LHU/SB/SH/SW) and flags misaligned accesses without touching memory.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, data width; only 32 supported (4 byte lanes)
TIMEOUT_CYCLES, 255, bus-wait limit in cycles; used only with LSU_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  EXU request valid
req_ready  out  1  controller can accept a request
req_wen  in  1  1=store, 0=load
req_funct3  in  3  RV32 funct3 width/sign code
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, LSB-justified
resp_valid  out  1  response valid
resp_ready  in  1  EXU accepts response
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
resp_err  out  1  1=misaligned or bus error/timeout
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accepts request
mem_wen  out  1  bus write
mem_addr  out  ADDR_WIDTH  req_addr with [1:0] forced to 0
mem_wdata  out  DATA_WIDTH  store data replicated into lanes
mem_wstrb  out  4  byte-lane write enables; 0 for reads
mem_rvalid  in  1  bus read data / write ack valid
mem_rdata  in  DATA_WIDTH  bus read word
mem_rerr  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0 except req_ready=1. Internal latches cleared.
- States are IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch wen, funct3, addr, and wdata.
  - If misaligned (H with addr[0]=1; W with addr[1:0]≠0), go to RESP with err=1, rdata=0, and no bus activity.
  - If funct3 is illegal (load 3/6/7; store ≥3), go to RESP with err=1.
  - Otherwise go to REQ.
- REQ: mem_valid=1 with stable addr, wen, wdata, and wstrb until mem_ready. On mem_valid&mem_ready, go to WAIT. If mem_rvalid coincides with this handshake, it is accepted in the same cycle and the FSM goes directly to RESP.
- WAIT: on mem_rvalid, capture the result (load: extract; store: rdata=0) and set err=mem_rerr, then go to RESP.
- RESP: resp_valid=1; rdata and err are held stable until resp_ready. On handshake go to IDLE, where req_ready=1 on the next cycle. There is no back-to-back acceptance in the RESP cycle.
- Minimum latency from request accept to resp_valid is 2 cycles with a zero-wait bus; a misaligned request takes 1 cycle.
- Store lanes, with off=addr[1:0]:
  - SB: wstrb=0001<<off; wdata=byte replicated ×4.
  - SH: wstrb=0011<<off; wdata=half replicated ×2.
  - SW: wstrb=1111.
- Load extract: byte=rdata[8*off+:8], half=rdata[16*off[1]+:16].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Inputs other than req_valid are ignored outside IDLE. The EXU must not change request fields while req_valid&!req_ready.
- Reset during REQ/WAIT aborts the transfer; a later stale mem_rvalid arriving in IDLE is ignored.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on entry to REQ and increments every cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES, go to RESP with err=1 and rdata=0, and drop mem_valid.
- Undefined: no counter; the controller waits indefinitely in REQ/WAIT.

Test Plan:
- LB addr=0x8000_0003, bus word 0x80FF_1234, zero-wait → resp_rdata=0xFFFF_FF80, err=0, resp_valid 2 cycles after accept.
- LHU addr=0x8000_0002, word 0x8001_7FFF → rdata=0x0000_8001; LH same addr → 0xFFFF_8001; LW addr=0x8000_0000 → 0x8001_7FFF.
- SB addr=0x8000_0001, wdata=0x1234_56AB → mem_wstrb=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x8000_0000; SH addr=0x...2 → wstrb=1100, wdata=0x56AB_56AB.
- LW addr=0x8000_0002 → resp_err=1, rdata=0, mem_valid never asserted; then a legal LW is accepted after the resp handshake.
- Bus stalls: mem_ready low 3 cycles and resp_ready low 2 cycles → mem_* and resp_* stay stable throughout; mem_rerr=1 → resp_err=1.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 → resp_err=1 at the timeout. Also assert rst mid-WAIT → outputs reset immediately, req_ready=1.

Source files
------------

// File: rtl/ysyx_24100012_lsu_ctrl_if.sv
// ysyx_24100012_lsu_ctrl_if: EXU request/response and data-memory bus signals for the LSU controller.
// Ports (signals): req_valid/req_ready/req_wen/req_funct3/req_addr/req_wdata (EXU request),
//   resp_valid/resp_ready/resp_rdata/resp_err (EXU response),
//   mem_valid/mem_ready/mem_wen/mem_addr/mem_wdata/mem_wstrb (bus request),
//   mem_rvalid/mem_rdata/mem_rerr (bus result).
// Modports: slave = the LSU controller, master = the EXU plus memory side.
interface ysyx_24100012_lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rerr;
  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
           mem_ready, mem_rvalid, mem_rdata, mem_rerr,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
           mem_ready, mem_rvalid, mem_rdata, mem_rerr,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/ysyx_24100012_lsu_ctrl.sv
// ysyx_24100012_lsu_ctrl: multi-cycle RV32 load/store controller between the EXU and the data-memory bus.
// Ports: clk (rising edge), rst (asynchronous, active low), b (ysyx_24100012_lsu_ctrl_if.slave:
//   EXU request/response handshakes and word-aligned memory bus with byte strobes).
// Optional: define LSU_TIMEOUT_EN to abort a bus transfer with err=1 after TIMEOUT_CYCLES cycles.
module ysyx_24100012_lsu_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_24100012_lsu_ctrl_if.slave b
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  state_e                state_q;
  logic                  wen_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  mem_valid_q;
  logic                  mem_wen_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [3:0]            mem_wstrb_q;
  logic [1:0]            off;
  logic [2:0]            f3;
  logic                  bad;
  logic [3:0]            strb;
  logic [DATA_WIDTH-1:0] wdata;
  logic [7:0]            lb;
  logic [15:0]           lh;
  logic [DATA_WIDTH-1:0] fin;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;
`endif
  always_comb begin
    off   = b.req_addr[1:0];
    f3    = b.req_funct3;
    // misaligned half/word, or a funct3 with no RV32 load/store meaning
    bad   = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00) ||
            (b.req_wen ? f3 > 3'd2 : (f3 == 3'd3 || f3[2:1] == 2'b11));
    strb  = !b.req_wen ? 4'b0000 : f3[1:0] == 2'b00 ? 4'b0001 << off :
            f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata = !b.req_wen ? '0 : f3[1:0] == 2'b00 ? {4{b.req_wdata[7:0]}} :
            f3[1:0] == 2'b01 ? {2{b.req_wdata[15:0]}} : b.req_wdata;
    lb    = b.mem_rdata[8*off_q +: 8];
    lh    = b.mem_rdata[16*off_q[1] +: 16];
    fin   = wen_q ? '0 : f3_q == 3'd0 ? {{24{lb[7]}}, lb} : f3_q == 3'd1 ? {{16{lh[15]}}, lh} :
            f3_q == 3'd4 ? {24'b0, lb} : f3_q == 3'd5 ? {16'b0, lh} : b.mem_rdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (b.req_valid) begin
          wen_q       <= b.req_wen;
          f3_q        <= f3;
          off_q       <= off;
          req_ready_q <= 1'b0;
          if (bad) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q     <= REQ;
            mem_valid_q <= 1'b1;
            mem_wen_q   <= b.req_wen;
            mem_addr_q  <= {b.req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_q <= wdata;
            mem_wstrb_q <= strb;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        REQ, WAIT: begin
          if (state_q == REQ && b.mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
          // a result coinciding with the REQ handshake skips WAIT entirely
          if ((state_q == WAIT || b.mem_ready) && b.mem_rvalid) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= fin;
            resp_err_q   <= b.mem_rerr;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_valid_q  <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
          end
          cnt_q <= cnt_q + 1'b1;
`endif
        end
        RESP: if (b.resp_ready) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign b.req_ready  = req_ready_q;
  assign b.resp_valid = resp_valid_q;
  assign b.resp_rdata = resp_rdata_q;
  assign b.resp_err   = resp_err_q;
  assign b.mem_valid  = mem_valid_q;
  assign b.mem_wen    = mem_wen_q;
  assign b.mem_addr   = mem_addr_q;
  assign b.mem_wdata  = mem_wdata_q;
  assign b.mem_wstrb  = mem_wstrb_q;
endmodule

// File: tb/tb_ysyx_24100012_lsu_ctrl.sv
// tb_ysyx_24100012_lsu_ctrl: directed table-driven bench for the LSU controller plus stall/reset/timeout sequences.
module tb_ysyx_24100012_lsu_ctrl;
  logic clk;
  logic rst;
  logic zero_wait;
  logic rvalid_man;
  int   tests;
  int   fails;
  ysyx_24100012_lsu_ctrl_if bif ();
  ysyx_24100012_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .b(bif.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bif.mem_rvalid = zero_wait ? (bif.mem_valid && bif.mem_ready) : rvalid_man;
  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_bus;
    logic [3:0]  e_strb;
    logic [31:0] e_mwdata;
    int          e_lat;
  } vec_t;
  vec_t vecs[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rword);
    @(negedge clk);
    bif.req_wen    = wen;
    bif.req_funct3 = f3;
    bif.req_addr   = addr;
    bif.req_wdata  = wdata;
    bif.mem_rdata  = rword;
    bif.req_valid  = 1'b1;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic saw, mw;
    logic [3:0] st;
    logic [31:0] wd, ma;
    lat = 0;
    saw = 1'b0;
    mw = 1'b0;
    st = 4'h0;
    wd = '0;
    ma = '0;
    issue(v.wen, v.f3, v.addr, v.wdata, v.rword);
    do begin
      @(negedge clk);
      lat++;
      if (bif.mem_valid && !saw) begin
        saw = 1'b1;
        st = bif.mem_wstrb;
        wd = bif.mem_wdata;
        ma = bif.mem_addr;
        mw = bif.mem_wen;
      end
    end while (!bif.resp_valid && lat < 20);
    chk($sformatf("v%0d_resp_valid", idx), {31'b0, bif.resp_valid}, 32'd1);
    chk($sformatf("v%0d_latency", idx), lat, v.e_lat);
    chk($sformatf("v%0d_err", idx), {31'b0, bif.resp_err}, {31'b0, v.e_err});
    chk($sformatf("v%0d_rdata", idx), bif.resp_rdata, v.e_rdata);
    chk($sformatf("v%0d_bus_used", idx), {31'b0, saw}, {31'b0, v.e_bus});
    if (v.e_bus) begin
      chk($sformatf("v%0d_wstrb", idx), {28'b0, st}, {28'b0, v.e_strb});
      chk($sformatf("v%0d_maddr", idx), ma, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_mwen", idx), {31'b0, mw}, {31'b0, v.wen});
      if (v.wen) chk($sformatf("v%0d_mwdata", idx), wd, v.e_mwdata);
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready_after", idx), {30'b0, bif.req_ready, bif.resp_valid}, 32'd2);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    zero_wait = 1'b1;
    rvalid_man = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_wen = 1'b0;
    bif.req_funct3 = 3'd0;
    bif.req_addr = '0;
    bif.req_wdata = '0;
    bif.resp_ready = 1'b1;
    bif.mem_ready = 1'b1;
    bif.mem_rdata = '0;
    bif.mem_rerr = 1'b0;
    vecs[0]  = '{1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 1'b1, 4'h0, 32'h0, 2};
    vecs[1]  = '{1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 1'b0, 32'h0000_8001, 1'b1, 4'h0, 32'h0, 2};
    vecs[2]  = '{1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 1'b0, 32'hFFFF_8001, 1'b1, 4'h0, 32'h0, 2};
    vecs[3]  = '{1'b0, 3'd2, 32'h8000_0000, 32'h0, 32'h8001_7FFF, 1'b0, 32'h8001_7FFF, 1'b1, 4'h0, 32'h0, 2};
    vecs[4]  = '{1'b0, 3'd4, 32'h8000_0001, 32'h0, 32'h80FF_1234, 1'b0, 32'h0000_0012, 1'b1, 4'h0, 32'h0, 2};
    vecs[5]  = '{1'b0, 3'd0, 32'h8000_0002, 32'h0, 32'h80FF_1234, 1'b0, 32'hFFFF_FFFF, 1'b1, 4'h0, 32'h0, 2};
    vecs[6]  = '{1'b0, 3'd1, 32'h8000_0000, 32'h0, 32'h8001_7FFF, 1'b0, 32'h0000_7FFF, 1'b1, 4'h0, 32'h0, 2};
    vecs[7]  = '{1'b1, 3'd0, 32'h8000_0001, 32'h1234_56AB, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 4'b0010, 32'hABAB_ABAB, 2};
    vecs[8]  = '{1'b1, 3'd1, 32'h8000_0002, 32'h1234_56AB, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 4'b1100, 32'h56AB_56AB, 2};
    vecs[9]  = '{1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 2};
    vecs[10] = '{1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1};
    vecs[11] = '{1'b0, 3'd2, 32'h8000_0000, 32'h0, 32'h8001_7FFF, 1'b0, 32'h8001_7FFF, 1'b1, 4'h0, 32'h0, 2};
    vecs[12] = '{1'b0, 3'd1, 32'h8000_0001, 32'h0, 32'h8001_7FFF, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1};
    vecs[13] = '{1'b1, 3'd1, 32'h8000_0003, 32'h1234_56AB, 32'h0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1};
    vecs[14] = '{1'b0, 3'd6, 32'h8000_0000, 32'h0, 32'h8001_7FFF, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1};
    vecs[15] = '{1'b1, 3'd4, 32'h8000_0000, 32'h1234_56AB, 32'h0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1};
    @(negedge clk);
    @(negedge clk);
    chk("reset_req_ready", {31'b0, bif.req_ready}, 32'd1);
    chk("reset_resp_valid", {31'b0, bif.resp_valid}, 32'd0);
    chk("reset_mem_valid", {31'b0, bif.mem_valid}, 32'd0);
    chk("reset_resp_err", {31'b0, bif.resp_err}, 32'd0);
    chk("reset_wstrb", {28'b0, bif.mem_wstrb}, 32'd0);
    chk("reset_rdata", bif.resp_rdata, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);
    zero_wait = 1'b0;
    bif.mem_ready = 1'b0;
    bif.resp_ready = 1'b0;
    issue(1'b1, 3'd1, 32'h8000_0002, 32'h1234_56AB, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_mem_valid", i), {31'b0, bif.mem_valid}, 32'd1);
      chk($sformatf("stall%0d_maddr", i), bif.mem_addr, 32'h8000_0000);
      chk($sformatf("stall%0d_wstrb", i), {28'b0, bif.mem_wstrb}, 32'hC);
      chk($sformatf("stall%0d_wdata", i), bif.mem_wdata, 32'h56AB_56AB);
      chk($sformatf("stall%0d_mwen", i), {31'b0, bif.mem_wen}, 32'd1);
    end
    bif.mem_ready = 1'b1;
    @(negedge clk);
    bif.mem_ready = 1'b0;
    chk("wait_mem_valid", {31'b0, bif.mem_valid}, 32'd0);
    chk("wait_resp_valid", {31'b0, bif.resp_valid}, 32'd0);
    rvalid_man = 1'b1;
    bif.mem_rerr = 1'b1;
    @(negedge clk);
    rvalid_man = 1'b0;
    bif.mem_rerr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstall%0d_resp_valid", i), {31'b0, bif.resp_valid}, 32'd1);
      chk($sformatf("rstall%0d_err", i), {31'b0, bif.resp_err}, 32'd1);
      chk($sformatf("rstall%0d_rdata", i), bif.resp_rdata, 32'd0);
      chk($sformatf("rstall%0d_req_ready", i), {31'b0, bif.req_ready}, 32'd0);
      if (i == 2) bif.resp_ready = 1'b1;
      @(negedge clk);
    end
    chk("rstall_done", {30'b0, bif.req_ready, bif.resp_valid}, 32'd2);
    bif.mem_ready = 1'b1;
    issue(1'b0, 3'd2, 32'h8000_0000, 32'h0, 32'h8001_7FFF);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wait", {30'b0, bif.mem_valid, bif.resp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", {31'b0, bif.req_ready}, 32'd1);
    chk("abort_mem_valid", {31'b0, bif.mem_valid}, 32'd0);
    chk("abort_maddr", bif.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rvalid_man = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rvalid_man = 1'b0;
    chk("stale_resp_valid", {31'b0, bif.resp_valid}, 32'd0);
    chk("stale_req_ready", {31'b0, bif.req_ready}, 32'd1);
`ifdef LSU_TIMEOUT_EN
    begin
      int lat;
      bif.mem_ready = 1'b0;
      issue(1'b0, 3'd2, 32'h8000_0000, 32'h0, 32'h8001_7FFF);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bif.resp_valid && lat < 20);
      chk("timeout_latency", lat, 32'd5);
      chk("timeout_err", {31'b0, bif.resp_err}, 32'd1);
      chk("timeout_rdata", bif.resp_rdata, 32'd0);
      chk("timeout_mem_valid", {31'b0, bif.mem_valid}, 32'd0);
      @(negedge clk);
      bif.mem_ready = 1'b1;
    end
`endif
    zero_wait = 1'b1;
    run_vec(vecs[0], 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
